// File: rtl/spi_command_sequencer.sv
// spi_command_sequencer
//   Command front end for spi_master. Single-word SPI commands are queued in a
//   small FIFO and launched one at a time through the enable/busy handshake.
//   Each popped command produces exactly one response (read data + status) on a
//   valid/ready port. Commands are served strictly in push order.
//
// Ports
//   clock, reset             rising-edge clock, synchronous active-high reset
//   command_*                valid/ready command input (read_write, address, data)
//   response_*               valid/ready response output (data, read echo, error)
//   master_*                 handshake and command fields toward spi_master
//   queue_level              current FIFO occupancy
module spi_command_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 15,
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 1024
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          command_valid,
  output logic                          command_ready,
  input  logic                          command_read_write,
  input  logic [ADDRESS_WIDTH-1:0]      command_address,
  input  logic [DATA_WIDTH-1:0]         command_data,
  output logic                          response_valid,
  input  logic                          response_ready,
  output logic [DATA_WIDTH-1:0]         response_data,
  output logic                          response_read,
  output logic                          response_error,
  output logic [DATA_WIDTH-1:0]         master_data,
  output logic [ADDRESS_WIDTH-1:0]      master_address,
  output logic                          master_read_write,
  output logic                          master_enable,
  input  logic                          master_busy,
  input  logic [DATA_WIDTH-1:0]         master_read_data,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

  typedef struct packed {
    logic                     read_write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    data;
  } cmd_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_START, S_WAIT_DONE, S_RESPOND} state_t;

  state_t           state, state_next;
  cmd_t             fifo_mem [FIFO_DEPTH];
  cmd_t             cmd_in, cmd_head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   level;
  logic [CNT_W-1:0] start_cnt;
  logic             push, pop, full, empty, start_expired;

  assign cmd_in        = '{read_write: command_read_write, address: command_address, data: command_data};
  assign cmd_head      = fifo_mem[rd_ptr];
  assign full          = (level == (PTR_W+1)'(FIFO_DEPTH));
  assign empty         = (level == '0);
  assign command_ready = !full;
  assign push          = command_valid && command_ready;
  assign queue_level   = level;
  // Counter holds the number of WAIT_START cycles already spent without busy.
  assign start_expired = (start_cnt == CNT_W'(START_TIMEOUT - 1));

  // Storage carries no reset; validity is tracked by level/pointers.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= cmd_in;
  end

  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        // Also wait for busy low: after a reset the master may still be
        // finishing an abandoned transfer.
        if (!empty && !response_valid && !master_busy) begin
          pop        = 1'b1;
          state_next = S_WAIT_START;
        end
      end
      S_WAIT_START: begin
        if (master_busy)        state_next = S_WAIT_DONE;
        else if (start_expired) state_next = S_RESPOND;
      end
      S_WAIT_DONE: begin
        if (!master_busy) state_next = S_RESPOND;
      end
      S_RESPOND: begin
        if (response_valid && response_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      level             <= '0;
      start_cnt         <= '0;
      master_data       <= '0;
      master_address    <= '0;
      master_read_write <= 1'b0;
      master_enable     <= 1'b0;
      response_valid    <= 1'b0;
      response_data     <= '0;
      response_read     <= 1'b0;
      response_error    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + (PTR_W+1)'(1);
        2'b01:   level <= level - (PTR_W+1)'(1);
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (pop) begin
            master_data       <= cmd_head.data;
            master_address    <= cmd_head.address;
            master_read_write <= cmd_head.read_write;
            master_enable     <= 1'b1;
            start_cnt         <= '0;
          end
        end
        S_WAIT_START: begin
          if (master_busy) begin
            master_enable <= 1'b0;
          end else if (start_expired) begin
            master_enable  <= 1'b0;
            response_valid <= 1'b1;
            response_error <= 1'b1;
            response_data  <= '0;
            response_read  <= master_read_write;
          end else begin
            start_cnt <= start_cnt + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!master_busy) begin
            response_data  <= master_read_write ? master_read_data : '0;
            response_read  <= master_read_write;
            response_error <= 1'b0;
            response_valid <= 1'b1;
          end
        end
        S_RESPOND: begin
          if (response_ready) response_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_command_sequencer.sv
// Directed bench for spi_command_sequencer: a vector table for single commands,
// plus hand sequences for FIFO full, start timeout, mid-transfer reset and
// response backpressure. A small spi_master model raises busy one cycle after
// enable and returns address-derived read data when busy falls.
module tb_spi_command_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        command_valid = 1'b0;
  logic        command_ready;
  logic        command_read_write = 1'b0;
  logic [14:0] command_address = '0;
  logic [15:0] command_data = '0;
  logic        response_valid;
  logic        response_ready = 1'b0;
  logic [15:0] response_data;
  logic        response_read;
  logic        response_error;
  logic [15:0] master_data;
  logic [14:0] master_address;
  logic        master_read_write;
  logic        master_enable;
  logic        master_busy = 1'b0;
  logic [15:0] master_read_data = '0;
  logic [2:0]  queue_level;

  int checks   = 0;
  int failures = 0;
  int busy_len = 3;
  logic model_on = 1'b1;
  int en_run  = 0;
  int en_last = 0;

  spi_command_sequencer #(
    .DATA_WIDTH(16), .ADDRESS_WIDTH(15), .FIFO_DEPTH(4), .START_TIMEOUT(8)
  ) dut (
    .clock(clock), .reset(reset),
    .command_valid(command_valid), .command_ready(command_ready),
    .command_read_write(command_read_write), .command_address(command_address),
    .command_data(command_data),
    .response_valid(response_valid), .response_ready(response_ready),
    .response_data(response_data), .response_read(response_read),
    .response_error(response_error),
    .master_data(master_data), .master_address(master_address),
    .master_read_write(master_read_write), .master_enable(master_enable),
    .master_busy(master_busy), .master_read_data(master_read_data),
    .queue_level(queue_level)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] model_data(input logic [14:0] a);
    return (a == 15'h7FFF) ? 16'h1234 : ({1'b0, a} + 16'h0100);
  endfunction

  // spi_master stand-in
  initial begin
    forever begin
      @(negedge clock);
      if (master_enable && model_on && !master_busy) begin
        master_busy = 1'b1;
        repeat (busy_len) @(negedge clock);
        master_read_data = model_data(master_address);
        master_busy = 1'b0;
      end
    end
  end

  // Length of the most recent enable-high run, in cycles.
  always @(negedge clock) begin
    if (master_enable) en_run <= en_run + 1;
    else if (en_run != 0) begin
      en_last <= en_run;
      en_run  <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Call at a negedge; returns at a negedge with command_valid low.
  task automatic push(input logic rw, input logic [14:0] a, input logic [15:0] d);
    int n = 0;
    command_valid = 1'b1; command_read_write = rw; command_address = a; command_data = d;
    while (!command_ready && n < 500) begin @(negedge clock); n++; end
    if (!command_ready) chk("push_ready_timeout", 32'(command_ready), 1);
    @(posedge clock);
    @(negedge clock);
    command_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic er, input logic [15:0] ed,
                           input logic ee, input logic [14:0] ea);
    int n = 0;
    while (!response_valid && n < 500) begin @(negedge clock); n++; end
    chk({name, "_valid"}, 32'(response_valid), 1);
    if (!response_valid) return;
    chk({name, "_read"},  32'(response_read),  32'(er));
    chk({name, "_data"},  32'(response_data),  32'(ed));
    chk({name, "_error"}, 32'(response_error), 32'(ee));
    chk({name, "_addr"},  32'(master_address), 32'(ea));
    response_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    response_ready = 1'b0;
  endtask

  typedef struct {
    logic        rw;
    logic [14:0] addr;
    logic [15:0] data;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  initial begin
    bit stable, no_launch;
    int n;

    vecs[0] = '{1'b1, 15'h0000, 16'h0000, 16'h0100};
    vecs[1] = '{1'b0, 15'h4000, 16'hFFFF, 16'h0000};
    vecs[2] = '{1'b1, 15'h0123, 16'hAAAA, 16'h0223};
    vecs[3] = '{1'b1, 15'h7FFF, 16'h0000, 16'h1234};
    vecs[4] = '{1'b1, 15'h7FFE, 16'h0000, 16'h80FE};

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_ready",   32'(command_ready),  1);
    chk("rst_level",   32'(queue_level),    0);
    chk("rst_enable",  32'(master_enable),  0);
    chk("rst_rvalid",  32'(response_valid), 0);
    chk("rst_rdata",   32'(response_data),  0);
    chk("rst_rerror",  32'(response_error), 0);
    chk("rst_maddr",   32'(master_address), 0);
    chk("rst_mdata",   32'(master_data),    0);
    reset = 1'b0;
    @(negedge clock);

    // write with a long busy phase
    busy_len = 40;
    push(1'b0, 15'h0012, 16'hBEEF);
    @(negedge clock);
    chk("w_enable", 32'(master_enable),     1);
    chk("w_maddr",  32'(master_address),    32'h12);
    chk("w_mdata",  32'(master_data),       32'hBEEF);
    chk("w_mrw",    32'(master_read_write), 0);
    @(negedge clock);
    chk("w_enable_drop", 32'(master_enable), 0);
    wait_resp("w", 1'b0, 16'h0000, 1'b0, 15'h0012);
    chk("w_mdata_hold", 32'(master_data), 32'hBEEF);

    // table vectors
    busy_len = 3;
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].rw, vecs[i].addr, vecs[i].data);
      wait_resp($sformatf("vec%0d", i), vecs[i].rw, vecs[i].exp_rdata, 1'b0, vecs[i].addr);
    end

    // five back-to-back pushes with responses held off
    for (int i = 0; i < 5; i++) push(1'b1, 15'(16 + i), 16'h0000);
    chk("full_level", 32'(queue_level),   4);
    chk("full_ready", 32'(command_ready), 0);
    for (int i = 0; i < 5; i++)
      wait_resp($sformatf("fifo%0d", i), 1'b1, 16'(16'h0110 + i), 1'b0, 15'(16 + i));
    chk("fifo_empty", 32'(queue_level), 0);

    // start timeout, then the next command launches normally
    model_on = 1'b0;
    push(1'b1, 15'h0055, 16'h0000);
    push(1'b0, 15'h0066, 16'h1111);
    n = 0;
    while (!response_valid && n < 100) begin @(negedge clock); n++; end
    model_on = 1'b1;
    @(negedge clock);
    chk("to_enable_cycles", 32'(en_last), 8);
    wait_resp("to", 1'b1, 16'h0000, 1'b1, 15'h0055);
    wait_resp("after_to", 1'b0, 16'h0000, 1'b0, 15'h0066);

    // reset while the master is busy with two commands queued
    busy_len = 10;
    push(1'b0, 15'h0001, 16'h0001);
    push(1'b0, 15'h0002, 16'h0002);
    push(1'b0, 15'h0003, 16'h0003);
    @(negedge clock);
    chk("prerst_level", 32'(queue_level), 2);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_enable", 32'(master_enable),  0);
    chk("midrst_level",  32'(queue_level),    0);
    chk("midrst_rvalid", 32'(response_valid), 0);
    chk("midrst_ready",  32'(command_ready),  1);
    reset = 1'b0;
    busy_len = 3;
    push(1'b1, 15'h0200, 16'h0000);
    wait_resp("postrst", 1'b1, 16'h0300, 1'b0, 15'h0200);

    // response held for 20 cycles
    push(1'b0, 15'h0A00, 16'h5555);
    push(1'b1, 15'h0A01, 16'h0000);
    push(1'b1, 15'h0A02, 16'h0000);
    n = 0;
    while (!response_valid && n < 100) begin @(negedge clock); n++; end
    stable = 1'b1;
    no_launch = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (!(response_valid && response_data == 16'h0 && !response_read && !response_error))
        stable = 1'b0;
      if (master_enable) no_launch = 1'b0;
    end
    chk("bp_stable",    32'(stable),      1);
    chk("bp_no_launch", 32'(no_launch),   1);
    chk("bp_level",     32'(queue_level), 2);
    push(1'b1, 15'h0A03, 16'h0000);
    chk("bp_fill",      32'(queue_level), 3);
    wait_resp("bp0", 1'b0, 16'h0000, 1'b0, 15'h0A00);
    wait_resp("bp1", 1'b1, 16'h0B01, 1'b0, 15'h0A01);
    wait_resp("bp2", 1'b1, 16'h0B02, 1'b0, 15'h0A02);
    wait_resp("bp3", 1'b1, 16'h0B03, 1'b0, 15'h0A03);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
